// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter
// Shares the single-port data memory between the CPU micro-instruction path
// and a debug/loader port. CPU accesses pass straight through. A debug
// access wins when the CPU is idle, or once it has lost STARVE_LIMIT cycles
// in a row, in which case the CPU is stalled for that one cycle.
//
// Ports:
//   clk, reset                      clock, asynchronous active-low reset
//   cpu_mem_instruction/addr/wdata  CPU memory micro-op
//   cpu_stall                       CPU must hold and re-issue next cycle
//   dbg_req/we/addr/wdata           debug request (held until dbg_ack)
//   dbg_ack, dbg_rdata              completion pulse, read data
//   mem_instruction/addr/wdata      to data_mem
//   mem_rdata                       from data_mem bus_out (registered)
//
// Optional build macro DATA_MEM_ARB_PERF_EN adds the stall_count and
// dbg_grant_count outputs (16-bit, saturating).
//
// The encoding macros below are supplied by the project headers; the
// fallbacks only keep this file self-contained.

`ifndef WORD_SIZE
`define WORD_SIZE 4
`endif
`ifndef MEM_MICRO_INSTRUCTION_SIZE
`define MEM_MICRO_INSTRUCTION_SIZE 2
`endif
`ifndef MEM_BUSTORAM
`define MEM_BUSTORAM 2'd1
`endif
`ifndef MEM_RAMTOBUS
`define MEM_RAMTOBUS 2'd2
`endif

module data_mem_arbiter #(
   parameter int STARVE_LIMIT = 4,
   parameter logic [`MEM_MICRO_INSTRUCTION_SIZE-1:0] IDLE_CODE = '0
) (
   input  logic                                   clk,
   input  logic                                   reset,
   input  logic [`MEM_MICRO_INSTRUCTION_SIZE-1:0] cpu_mem_instruction,
   input  logic [`WORD_SIZE-1:0]                  cpu_addr,
   input  logic [`WORD_SIZE-1:0]                  cpu_wdata,
   output logic                                   cpu_stall,
   input  logic                                   dbg_req,
   input  logic                                   dbg_we,
   input  logic [`WORD_SIZE-1:0]                  dbg_addr,
   input  logic [`WORD_SIZE-1:0]                  dbg_wdata,
   output logic                                   dbg_ack,
   output logic [`WORD_SIZE-1:0]                  dbg_rdata,
   output logic [`MEM_MICRO_INSTRUCTION_SIZE-1:0] mem_instruction,
   output logic [`WORD_SIZE-1:0]                  mem_addr,
   output logic [`WORD_SIZE-1:0]                  mem_wdata,
   input  logic [`WORD_SIZE-1:0]                  mem_rdata
`ifdef DATA_MEM_ARB_PERF_EN
   ,
   output logic [15:0]                            stall_count,
   output logic [15:0]                            dbg_grant_count
`endif
);

   localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
   localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_RD_WAIT = 2'd1;
   localparam logic [1:0] S_ACK     = 2'd2;

   logic [1:0]    state, state_nxt;
   logic [CW-1:0] starve_cnt;
   logic          cpu_access;
   logic          dbg_win;

   always_comb begin
      cpu_access = (cpu_mem_instruction == `MEM_BUSTORAM) ||
                   (cpu_mem_instruction == `MEM_RAMTOBUS);
      // Gated by reset so nothing is granted (or stalled) while held in reset.
      dbg_win    = reset && (state == S_IDLE) && dbg_req &&
                   (!cpu_access || (starve_cnt >= LIMIT));
      cpu_stall  = dbg_win && cpu_access;

      mem_instruction = IDLE_CODE;
      mem_addr        = '0;
      mem_wdata       = '0;
      if (reset) begin
         if (dbg_win) begin
            mem_instruction = dbg_we ? `MEM_BUSTORAM : `MEM_RAMTOBUS;
            mem_addr        = dbg_addr;
            mem_wdata       = dbg_wdata;
         end else begin
            // Non-access CPU encodings are normalised to IDLE_CODE.
            mem_instruction = cpu_access ? cpu_mem_instruction : IDLE_CODE;
            mem_addr        = cpu_addr;
            mem_wdata       = cpu_wdata;
         end
      end
   end

   always_comb begin
      state_nxt = S_IDLE;
      case (state)
         S_IDLE:    if (dbg_win) state_nxt = dbg_we ? S_ACK : S_RD_WAIT;
         S_RD_WAIT: state_nxt = S_ACK;
         S_ACK:     state_nxt = S_IDLE;
         default:   state_nxt = S_IDLE;
      endcase
   end

   assign dbg_ack = (state == S_ACK);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= S_IDLE;
         starve_cnt <= '0;
         dbg_rdata  <= '0;
      end else begin
         state <= state_nxt;

         // Counts consecutive lost IDLE cycles; frozen while a debug op is
         // in flight so a held dbg_req does not accumulate credit.
         if (!dbg_req || dbg_win)
            starve_cnt <= '0;
         else if ((state == S_IDLE) && (starve_cnt < LIMIT))
            starve_cnt <= starve_cnt + CW'(1);

         // data_mem registers the read issued on the grant cycle, so the
         // value is on mem_rdata during RD_WAIT.
         if (state == S_RD_WAIT)
            dbg_rdata <= mem_rdata;
      end
   end

`ifdef DATA_MEM_ARB_PERF_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_count     <= '0;
         dbg_grant_count <= '0;
      end else begin
         if (cpu_stall && (stall_count != 16'hFFFF))
            stall_count <= stall_count + 16'd1;
         if (dbg_win && (dbg_grant_count != 16'hFFFF))
            dbg_grant_count <= dbg_grant_count + 16'd1;
      end
   end
`endif

endmodule

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
Shares the single-port data memory (data_mem) between the CPU micro-instruction path and a debug/loader port. CPU accesses pass through with zero added latency. A debug access is granted only when the CPU is not accessing memory, or when the debug request has waited STARVE_LIMIT cycles; in that case the CPU is stalled for one cycle. Sits between the control unit / debug bridge and data_mem, and drives data_mem's mem_instruction, instruction_value and bus_in.

Parameters:
STARVE_LIMIT, 4, cycles a pending debug request may lose before it preempts the CPU; 0 = debug always wins.
IDLE_CODE, 0, mem_instruction encoding driven when no access; must differ from `MEM_BUSTORAM and `MEM_RAMTOBUS.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
cpu_mem_instruction  in  `MEM_MICRO_INSTRUCTION_SIZE  CPU memory micro-op
cpu_addr  in  `WORD_SIZE  CPU address
cpu_wdata  in  `WORD_SIZE  CPU write data
cpu_stall  out  1  CPU must hold and re-issue its micro-op next cycle
dbg_req  in  1  debug request, held until dbg_ack
dbg_we  in  1  1 = write, 0 = read
dbg_addr  in  `WORD_SIZE  debug address
dbg_wdata  in  `WORD_SIZE  debug write data
dbg_ack  out  1  one-cycle completion pulse
dbg_rdata  out  `WORD_SIZE  debug read data, valid from the dbg_ack cycle and held until the next debug read
mem_instruction  out  `MEM_MICRO_INSTRUCTION_SIZE  to data_mem mem_instruction
mem_addr  out  `WORD_SIZE  to data_mem instruction_value
mem_wdata  out  `WORD_SIZE  to data_mem bus_in
mem_rdata  in  `WORD_SIZE  from data_mem bus_out

Behaviour:
- Definitions:
  - cpu_access = cpu_mem_instruction is `MEM_BUSTORAM or `MEM_RAMTOBUS.
  - dbg_win = (state==IDLE) && dbg_req && (!cpu_access || starve_cnt>=STARVE_LIMIT).
- FSM states: IDLE, RD_WAIT, ACK.
  - IDLE:
    - If dbg_win: drive the debug op this cycle. mem_instruction = dbg_we ? `MEM_BUSTORAM : `MEM_RAMTOBUS; mem_addr = dbg_addr; mem_wdata = dbg_wdata.
    - cpu_stall = cpu_access in that cycle.
    - Next state: RD_WAIT for a read, ACK for a write.
    - If not dbg_win: pass the CPU through; an idle CPU drives IDLE_CODE.
  - RD_WAIT: CPU passes through. At this cycle's end, dbg_rdata <= mem_rdata (data_mem's registered result of the granted read). Next state: ACK.
  - ACK: dbg_ack=1 for exactly this cycle. CPU passes through. No debug grant is evaluated in this state. Next state: IDLE.
- Requester handshake: deassert dbg_req or present a new request in the ACK cycle. A dbg_req still high in IDLE is treated as a new request.
- Latency from grant cycle N to dbg_ack:
  - Debug write: dbg_ack at N+1.
  - Debug read: dbg_ack at N+2.
- The CPU's bus_out is clobbered by a debug read. CPU reads are unaffected because a stalled CPU re-issues its read.
- starve_cnt (width $clog2(STARVE_LIMIT+1), minimum 1 bit):
  - Cleared on reset, on dbg_win, and when dbg_req=0.
  - Incremented when state==IDLE && dbg_req && !dbg_win; saturates at STARVE_LIMIT.
  - Holds in RD_WAIT and ACK.
- cpu_stall is combinational and is never asserted outside IDLE.
- Reset (reset=0, asynchronous, including mid-transaction):
  - state=IDLE, starve_cnt=0, dbg_ack=0, dbg_rdata=0.
  - While reset is low: mem_instruction=IDLE_CODE, cpu_stall=0, mem_addr=0, mem_wdata=0.
  - A transaction interrupted by reset is dropped with no dbg_ack; the requester re-issues it.
- Address and data widths are `WORD_SIZE throughout; no wrap or extension logic.

Optional Feature:
DATA_MEM_ARB_PERF_EN. When defined, two extra output ports:
- stall_count [15:0]: increments every cycle cpu_stall=1.
- dbg_grant_count [15:0]: increments on every dbg_win.
- Both saturate at 16'hFFFF and clear on reset.
When undefined, the ports and counters do not exist; all other behaviour is identical.

Test Plan:
1. CPU-only: cpu `MEM_BUSTORAM addr 3 data 4'hA, then `MEM_RAMTOBUS addr 3 -> mem_* mirror CPU in the same cycle, cpu_stall=0 throughout, mem_rdata=4'hA one cycle after the read.
2. Debug write while CPU idle: dbg_req=1, dbg_we=1, addr 5, data 4'h6 -> grant that cycle with mem_instruction=`MEM_BUSTORAM; dbg_ack pulses at N+1; a later CPU read of addr 5 returns 4'h6.
3. Debug read while CPU idle: memory[7]=4'h9, dbg read addr 7 -> dbg_ack at N+2 with dbg_rdata=4'h9; a CPU read issued in the RD_WAIT cycle is not stalled and does not corrupt dbg_rdata.
4. Starvation, STARVE_LIMIT=4: CPU issues an access every cycle, dbg_req held high -> debug granted on the 5th cycle with cpu_stall=1 for exactly that cycle; starve_cnt returns to 0.
5. Reset mid-read: assert reset low in the RD_WAIT cycle -> outputs go to reset values immediately and no dbg_ack occurs; after release, dbg_req still high is re-granted normally.
6. With DATA_MEM_ARB_PERF_EN defined, repeat scenario 4 twice -> stall_count=2, dbg_grant_count=2.
